// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit port.
// Holds funct3 codes, memory size codes, FSM states and the latched request.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] SZ_B    = 3'b000;
    localparam logic [2:0] SZ_H    = 3'b001;
    localparam logic [2:0] SZ_W    = 3'b010;
    localparam logic [2:0] SZ_IDLE = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic            split;
    } lsu_req_t;

    // Access width in bytes; only meaningful for legal funct3 codes.
    function automatic logic [2:0] nbytes_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load-data extension: sign- or zero-extends the assembled load value by funct3.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result_c
);

    always_comb begin
        result_c = data;
        case (funct3)
            F3_B:    result_c = {{24{data[7]}}, data[7:0]};
            F3_H:    result_c = {{16{data[15]}}, data[15:0]};
            F3_BU:   result_c = {24'h0, data[7:0]};
            F3_HU:   result_c = {16'h0, data[15:0]};
            default: result_c = data;
        endcase
    end

endmodule

// File: rtl/lsu_port.sv
// Load/store unit port: accepts one core request at a time, drives the data
// memory (splitting misaligned accesses into byte beats) and returns a response pulse.
module lsu_port
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES        = 4096,
    parameter bit          SPLIT_MISALIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            reqValid,
    output logic            reqReady,
    input  logic            reqWe,
    input  logic [2:0]      reqFunct3,
    input  logic [XLEN-1:0] reqAddr,
    input  logic [XLEN-1:0] reqWData,
    output logic            rspValid,
    output logic [XLEN-1:0] rspData,
    output logic            rspErr,
    output logic [XLEN-1:0] memAddr,
    output logic [XLEN-1:0] memWData,
    output logic [2:0]      memSize,
    output logic            memWEn,
    input  logic [XLEN-1:0] memRData
);

    state_t          state_q, state_d;
    lsu_req_t        req_q, req_d;
    logic [1:0]      beat_q, beat_d;
    logic [XLEN-1:0] asm_q, asm_d;
    logic            rsp_valid_d, rsp_err_d;
    logic [XLEN-1:0] rsp_data_d;
    logic [XLEN-1:0] ext_c;

    logic [2:0]      in_nbytes;
    logic [1:0]      in_mask;
    logic            in_f3_ok, in_range_ok, in_aligned, in_err;
    logic [1:0]      last_beat;

    // Incoming request classification, used only at acceptance.
    always_comb begin
        in_nbytes   = nbytes_of(reqFunct3);
        in_mask     = 2'(in_nbytes - 3'd1);
        in_aligned  = (reqAddr[1:0] & in_mask) == 2'b00;
        in_range_ok = ({1'b0, reqAddr} + 33'(in_nbytes) - 33'd1) < 33'(MEM_BYTES);
        case (reqFunct3)
            F3_B, F3_H, F3_W: in_f3_ok = 1'b1;
            F3_BU, F3_HU:     in_f3_ok = !reqWe;
            default:          in_f3_ok = 1'b0;
        endcase
        in_err = !in_f3_ok || !in_range_ok || (!in_aligned && !SPLIT_MISALIGNED);
    end

    assign last_beat = req_q.split ? 2'(nbytes_of(req_q.funct3) - 3'd1) : 2'd0;

    // Load assembly: byte lane per beat when split, full word otherwise.
    always_comb begin
        asm_d = asm_q;
        if (state_q == IDLE) begin
            asm_d = '0;
        end else if (state_q == ACCESS && !req_q.we) begin
            if (req_q.split) begin
                asm_d[{beat_q, 3'b000} +: 8] = memRData[7:0];
            end else begin
                asm_d = memRData;
            end
        end
    end

    lsu_extend u_extend (
        .data     (asm_d),
        .funct3   (req_q.funct3),
        .result_c (ext_c)
    );

    // Next-state, memory port and response decode.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        beat_d      = beat_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
        reqReady    = 1'b0;
        memAddr     = '0;
        memWData    = '0;
        memSize     = SZ_IDLE;
        memWEn      = 1'b0;

        case (state_q)
            IDLE: begin
                reqReady = 1'b1;
                if (reqValid) begin
                    req_d.we     = reqWe;
                    req_d.funct3 = reqFunct3;
                    req_d.addr   = reqAddr;
                    req_d.wdata  = reqWData;
                    req_d.split  = !in_aligned;
                    beat_d       = 2'd0;
                    if (in_err) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                memWEn = req_q.we;
                if (req_q.split) begin
                    memAddr  = req_q.addr + XLEN'(beat_q);
                    memSize  = SZ_B;
                    memWData = {24'h0, req_q.wdata[{beat_q, 3'b000} +: 8]};
                end else begin
                    memAddr  = req_q.addr;
                    memSize  = {1'b0, req_q.funct3[1:0]};
                    memWData = req_q.wdata;
                end
                if (beat_q == last_beat) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = req_q.we ? '0 : ext_c;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q  <= IDLE;
            req_q    <= '0;
            beat_q   <= 2'd0;
            asm_q    <= '0;
            rspValid <= 1'b0;
            rspErr   <= 1'b0;
            rspData  <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            beat_q   <= beat_d;
            asm_q    <= asm_d;
            rspValid <= rsp_valid_d;
            rspErr   <= rsp_err_d;
            rspData  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_lsu_port.sv
// Scoreboard bench for lsu_port: a byte-array memory model, directed requests
// with hand-computed responses, and a monitor that checks every response pulse.
module tb_lsu_port;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWe = 1'b0;
    logic [2:0]  reqFunct3 = 3'b000;
    logic [31:0] reqAddr = '0;
    logic [31:0] reqWData = '0;
    logic        rspValid;
    logic [31:0] rspData;
    logic        rspErr;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [2:0]  memSize;
    logic        memWEn;
    logic [31:0] memRData;

    always #5 clk = ~clk;

    lsu_port #(.MEM_BYTES(4096), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rstN(rstN),
        .reqValid(reqValid), .reqReady(reqReady), .reqWe(reqWe),
        .reqFunct3(reqFunct3), .reqAddr(reqAddr), .reqWData(reqWData),
        .rspValid(rspValid), .rspData(rspData), .rspErr(rspErr),
        .memAddr(memAddr), .memWData(memWData), .memSize(memSize),
        .memWEn(memWEn), .memRData(memRData)
    );

    // Memory model: combinational raw read, write on clock edge, backdoor preload.
    logic [7:0]  mem [0:4095];
    logic        bd_we = 1'b0;
    logic [11:0] bd_addr = '0;
    logic [7:0]  bd_data = '0;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
    } wr_t;
    wr_t wlog[$];

    always_comb begin
        logic [11:0] a;
        a = memAddr[11:0];
        memRData = '0;
        if (memAddr < 32'd4096) begin
            case (memSize)
                3'b000:  memRData = {24'h0, mem[a]};
                3'b001:  memRData = {16'h0, mem[a + 12'd1], mem[a]};
                3'b010:  memRData = {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
                default: memRData = '0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (memWEn) begin
            wlog.push_back('{addr: memAddr, size: memSize, data: memWData});
            if (memAddr < 32'd4093) begin
                mem[memAddr[11:0]] <= memWData[7:0];
                if (memSize != 3'b000) mem[memAddr[11:0] + 12'd1] <= memWData[15:8];
                if (memSize == 3'b010) begin
                    mem[memAddr[11:0] + 12'd2] <= memWData[23:16];
                    mem[memAddr[11:0] + 12'd3] <= memWData[31:24];
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int n_push = 0;
    int n_rsp = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Monitor: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rspValid) begin
            n_rsp++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got data 0x%08h err %0d with nothing outstanding", rspData, rspErr);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_data", rspData, mon_e.data);
                check("rsp_err", 32'(rspErr), 32'(mon_e.err));
                check("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Called at a negedge; leaves reqValid high so back-to-back calls overlap busy time.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] expd,
                        input logic experr, input int lat, output int waited);
        exp_t e;
        reqValid = 1'b1; reqWe = we; reqFunct3 = f3; reqAddr = addr; reqWData = wdata;
        waited = 0;
        while (!reqReady && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!reqReady) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got reqReady 0 expected 1 within 50 cycles");
            reqValid = 1'b0;
            return;
        end
        e.data = expd; e.err = experr; e.cyc = cyc + lat;
        sb.push_back(e);
        n_push++;
        @(negedge clk);
    endtask

    task automatic drain();
        reqValid = 1'b0;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        int w;
        int base;
        @(negedge clk);
        poke(12'h010, 8'h78); poke(12'h011, 8'h56); poke(12'h012, 8'h34); poke(12'h013, 8'h12);
        poke(12'h030, 8'h01); poke(12'h031, 8'h80);
        poke(12'h041, 8'h00); poke(12'h042, 8'h00); poke(12'h043, 8'hEE); poke(12'h044, 8'hEE);
        poke(12'hFFC, 8'h00); poke(12'hFFD, 8'h00); poke(12'hFFE, 8'h00); poke(12'hFFF, 8'h00);

        check("rst_rspValid", 32'(rspValid), 32'd0);
        check("rst_rspErr", 32'(rspErr), 32'd0);
        check("rst_rspData", rspData, 32'd0);
        check("rst_reqReady", 32'(reqReady), 32'd1);
        check("rst_memWEn", 32'(memWEn), 32'd0);
        check("rst_memSize", 32'(memSize), 32'd3);
        check("rst_memAddr", memAddr, 32'd0);
        rstN = 1'b1;
        @(negedge clk);

        // Aligned LW
        send(1'b0, 3'b010, 32'h10, 32'h0, 32'h12345678, 1'b0, 2, w);
        drain();

        // Misaligned SW split into four byte beats
        base = wlog.size();
        send(1'b1, 3'b010, 32'h21, 32'hAABBCCDD, 32'h0, 1'b0, 5, w);
        drain();
        check("sw_split_beats", 32'(wlog.size() - base), 32'd4);
        if (wlog.size() - base == 4) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] sw_val;
                sw_val = 32'hAABBCCDD;
                check("sw_beat_addr", wlog[base + k].addr, 32'h21 + 32'(k));
                check("sw_beat_size", 32'(wlog[base + k].size), 32'd0);
                check("sw_beat_byte", 32'(wlog[base + k].data[7:0]), 32'(sw_val[8*k +: 8]));
            end
        end

        // Readback and extension variants
        send(1'b0, 3'b010, 32'h21, 32'h0, 32'hAABBCCDD, 1'b0, 5, w);
        send(1'b0, 3'b001, 32'h30, 32'h0, 32'hFFFF8001, 1'b0, 2, w);
        send(1'b0, 3'b101, 32'h30, 32'h0, 32'h00008001, 1'b0, 2, w);
        send(1'b0, 3'b000, 32'h24, 32'h0, 32'hFFFFFFAA, 1'b0, 2, w);
        send(1'b0, 3'b100, 32'h24, 32'h0, 32'h000000AA, 1'b0, 2, w);
        send(1'b0, 3'b001, 32'h23, 32'h0, 32'hFFFFAABB, 1'b0, 3, w);
        send(1'b0, 3'b101, 32'h23, 32'h0, 32'h0000AABB, 1'b0, 3, w);
        drain();

        // Error cases: none may write memory
        base = wlog.size();
        send(1'b1, 3'b011, 32'h50, 32'h12345678, 32'h0, 1'b1, 1, w);
        send(1'b1, 3'b010, 32'hFFE, 32'h12345678, 32'h0, 1'b1, 1, w);
        send(1'b1, 3'b100, 32'h50, 32'h12345678, 32'h0, 1'b1, 1, w);
        send(1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, 1, w);
        drain();
        check("err_no_write", 32'(wlog.size() - base), 32'd0);
        send(1'b0, 3'b010, 32'hFFC, 32'h0, 32'h0, 1'b0, 2, w);
        drain();

        // Back-to-back with reqValid held: payload changes while busy must not be latched
        send(1'b0, 3'b010, 32'h10, 32'h0, 32'h12345678, 1'b0, 2, w);
        check("b2b_first_wait", 32'(w), 32'd0);
        send(1'b0, 3'b101, 32'h30, 32'h0, 32'h00008001, 1'b0, 2, w);
        check("b2b_wait_1beat", 32'(w), 32'd2);
        send(1'b0, 3'b010, 32'h21, 32'h0, 32'hAABBCCDD, 1'b0, 5, w);
        check("b2b_wait_after_1beat", 32'(w), 32'd2);
        send(1'b0, 3'b010, 32'h10, 32'h0, 32'h12345678, 1'b0, 2, w);
        check("b2b_wait_4beat", 32'(w), 32'd5);
        drain();

        // Reset during the second beat of a split SW at 0x41
        reqValid = 1'b1; reqWe = 1'b1; reqFunct3 = 3'b010; reqAddr = 32'h41; reqWData = 32'h44332211;
        @(negedge clk);
        reqValid = 1'b0;
        check("split_beat0_addr", memAddr, 32'h41);
        @(negedge clk);
        check("split_beat1_addr", memAddr, 32'h42);
        check("split_beat1_wen", 32'(memWEn), 32'd1);
        rstN = 1'b0;
        @(negedge clk);
        check("rst_mid_wen", 32'(memWEn), 32'd0);
        check("rst_mid_ready", 32'(reqReady), 32'd1);
        check("rst_mid_rspValid", 32'(rspValid), 32'd0);
        rstN = 1'b1;
        for (int i = 0; i < 8; i++) @(negedge clk);
        check("rst_mem_41", 32'(mem[12'h041]), 32'h11);
        check("rst_mem_42", 32'(mem[12'h042]), 32'h22);
        check("rst_mem_43", 32'(mem[12'h043]), 32'hEE);
        check("rst_mem_44", 32'(mem[12'h044]), 32'hEE);

        check("rsp_count", 32'(n_rsp), 32'(n_push));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
